// File: rtl/lut_cfg_pkg.sv
// Shared types and frame-size helpers for the LUT config loader.
// LUT_CFG_PARITY_EN adds the CHECK state for the trailing parity word.
package lut_cfg_pkg;

`ifdef LUT_CFG_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    DONE
  } state_t;
`endif

  function automatic int frame_w(
    input int mem_size
  );
    return 2 * mem_size + 1;
  endfunction

  function automatic int num_words(
    input int fw,
    input int ww
  );
    return (fw + ww - 1) / ww;
  endfunction

endpackage

// File: rtl/lut_sxx_cfg_loader_if.sv
// Inbound config word stream: valid/ready handshake.
// The loader is the slave; the word source is the master.
interface lut_sxx_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/lut_cfg_assembler.sv
// Word counter plus frame register for the LUT config loader.
// With LUT_CFG_PARITY_EN it also captures the parity word's bit 0.
module lut_cfg_assembler
  import lut_cfg_pkg::*;
#(
  parameter int FRAME_W = 33,
  parameter int WORD_W  = 8
) (
  input  logic               cclk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               acc,
  input  logic [WORD_W-1:0]  data,
  output logic               last,
`ifdef LUT_CFG_PARITY_EN
  output logic               full,
  output logic               par,
`endif
  output logic [FRAME_W-1:0] frame
);

  localparam int NUM_WORDS = num_words(FRAME_W, WORD_W);
  localparam int CW = $clog2(NUM_WORDS + 1);

  logic [CW-1:0] cnt;
  logic          at_max;

  assign at_max = (cnt == CW'(NUM_WORDS));
  assign last   = (cnt == CW'(NUM_WORDS - 1));

  // Saturates at NUM_WORDS; the parity slot reuses that value.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (acc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Only frame bits are stored; surplus bits of the last word drop.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (acc) begin
      for (int i = 0; i < FRAME_W; i++) begin
        if (cnt == CW'(i / WORD_W)) begin
          frame[i] <= data[i % WORD_W];
        end
      end
    end
  end

`ifdef LUT_CFG_PARITY_EN
  assign full = at_max;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (acc && at_max) begin
      par <= data[0];
    end
  end
`endif

endmodule

// File: rtl/lut_sxx_cfg_loader.sv
// Frame loader for a fracturable LUT: gathers words, pulses cen.
// Define LUT_CFG_PARITY_EN for a trailing even-parity check word.
module lut_sxx_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2 ** INPUTS,
  parameter int WORD_W   = 8
) (
  input  logic                  cclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  lut_sxx_cfg_loader_if.slave   cfg,
  output logic                  cen,
  output logic [2*MEM_SIZE:0]   config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int FRAME_W = frame_w(MEM_SIZE);

  state_t state;
  state_t nxt;

  logic clr;
  logic acc;
  logic last;
  logic ready;

`ifdef LUT_CFG_PARITY_EN
  logic full;
  logic par;
  logic par_ok;
`endif

  assign ready         = (state == LOAD);
  assign cfg.cfg_ready = ready;
  // abort beats a word offered in the same cycle
  assign acc = cfg.cfg_valid & ready & ~abort;

  lut_cfg_assembler #(
    .FRAME_W (FRAME_W),
    .WORD_W  (WORD_W)
  ) u_asm (
    .cclk  (cclk),
    .rst_n (rst_n),
    .clr   (clr),
    .acc   (acc),
    .data  (cfg.cfg_data),
    .last  (last),
`ifdef LUT_CFG_PARITY_EN
    .full  (full),
    .par   (par),
`endif
    .frame (config_out)
  );

`ifdef LUT_CFG_PARITY_EN
  assign par_ok = (par == ^config_out);
`endif

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    clr = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (start && !abort) begin
          nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          nxt = IDLE;
          clr = 1'b1;
`ifdef LUT_CFG_PARITY_EN
        end else if (acc && full) begin
          nxt = CHECK;
`else
        end else if (acc && last) begin
          nxt = COMMIT;
`endif
        end
      end
`ifdef LUT_CFG_PARITY_EN
      CHECK: begin
        nxt = par_ok ? COMMIT : IDLE;
      end
`endif
      COMMIT: begin
        nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  assign cen  = (state == COMMIT);
  assign done = (state == DONE);
  assign busy = (state != IDLE);

`ifdef LUT_CFG_PARITY_EN
  assign err = (state == CHECK) && !par_ok;
`else
  assign err = 1'b0;
  logic unused_last;
  assign unused_last = last;
`endif

endmodule
